// File: rtl/packet_arbiter_pkg.sv
// rtl/packet_arbiter_pkg.sv - shared constants, marker layout and grant state encoding for packet_arbiter
package packet_arbiter_pkg;

    localparam int MARKER_TAG_W = 16;
    localparam int MARKER_RUN_W = 16;
    localparam logic [MARKER_TAG_W-1:0] OVF_TAG = 16'hFFFF;

    typedef enum logic [1:0] {
        GRANT_IDLE  = 2'd0,
        GRANT_TRACE = 2'd1,
        GRANT_AUX   = 2'd2
    } grant_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - first-word-fall-through FIFO buffering trace packets
module packet_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (level == '0);

    // Storage carries no reset; level and pointers define what is valid.
    always_ff @(posedge mclk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - merges buffered trace packets and aux requests onto one output; PACKET_ARB_OVF_MARKER_EN adds overflow markers
module packet_arbiter
    import packet_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int AUX_MAX_WAIT = 64
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic [31:0]           trace_data,
    input  logic                  trace_strobe,
    input  logic [31:0]           aux_data,
    input  logic                  aux_req,
    output logic                  aux_ack,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           overflow_count
);
    localparam int                WAIT_W   = $clog2(AUX_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(AUX_MAX_WAIT);

    grant_state_t      state;
    logic [WAIT_W-1:0] wait_count;
    logic [31:0]       fifo_head;
    logic [31:0]       push_data;
    logic              fifo_full, fifo_empty;
    logic              push, pop, drop, can_push;
    logic              slot_free, aux_elig, aux_urgent, grant_aux;

    assign slot_free  = !out_valid || out_ready;
    assign aux_elig   = aux_req && !aux_ack;
    assign aux_urgent = aux_elig && (wait_count >= WAIT_MAX);
    assign grant_aux  = slot_free && (aux_urgent || (aux_elig && fifo_empty));
    assign pop        = slot_free && !aux_urgent && !fifo_empty;
    assign can_push   = !fifo_full || pop;

`ifdef PACKET_ARB_OVF_MARKER_EN
    logic                    ovf_pending;
    logic                    write_marker;
    logic [MARKER_RUN_W-1:0] drop_run;

    // The marker takes the write slot, so a strobe on that edge is itself a drop.
    assign write_marker = ovf_pending && can_push;
    assign push         = write_marker || (trace_strobe && can_push);
    assign push_data    = write_marker ? {OVF_TAG, drop_run} : trace_data;
    assign drop         = trace_strobe && (write_marker || !can_push);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            ovf_pending <= 1'b0;
            drop_run    <= '0;
        end else if (write_marker) begin
            ovf_pending <= trace_strobe;
            drop_run    <= trace_strobe ? MARKER_RUN_W'(1) : '0;
        end else if (drop) begin
            ovf_pending <= 1'b1;
            drop_run    <= sat_inc16(drop_run);
        end
    end
`else
    assign push      = trace_strobe && can_push;
    assign push_data = trace_data;
    assign drop      = trace_strobe && !can_push;
`endif

    packet_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .mclk      (mclk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            overflow_count <= '0;
        end else if (drop) begin
            overflow_count <= sat_inc16(overflow_count);
        end
    end

    // Grant FSM: state records the source of the packet held in out_data.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state      <= GRANT_IDLE;
            out_data   <= '0;
            aux_ack    <= 1'b0;
            wait_count <= '0;
        end else begin
            aux_ack <= grant_aux;
            if (grant_aux) begin
                wait_count <= '0;
            end else if (aux_elig && wait_count != WAIT_MAX) begin
                wait_count <= wait_count + WAIT_W'(1);
            end
            if (slot_free) begin
                if (grant_aux) begin
                    state    <= GRANT_AUX;
                    out_data <= aux_data;
                end else if (pop) begin
                    state    <= GRANT_TRACE;
                    out_data <= fifo_head;
                end else begin
                    state    <= GRANT_IDLE;
                end
            end
        end
    end

    assign out_valid = (state != GRANT_IDLE);

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - directed and randomized checks of packet_arbiter against a queue model; honours PACKET_ARB_OVF_MARKER_EN
module tb_packet_arbiter;
    localparam int DEPTH_LOG2   = 4;
    localparam int DEPTH        = 16;
    localparam int AUX_MAX_WAIT = 64;

    logic                mclk = 1'b0;
    logic                reset;
    logic [31:0]         trace_data;
    logic                trace_strobe;
    logic [31:0]         aux_data;
    logic                aux_req;
    logic                aux_ack;
    logic [31:0]         out_data;
    logic                out_valid;
    logic                out_ready;
    logic [DEPTH_LOG2:0] fifo_level;
    logic [15:0]         overflow_count;

    packet_arbiter #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .AUX_MAX_WAIT (AUX_MAX_WAIT)
    ) dut (
        .mclk           (mclk),
        .reset          (reset),
        .trace_data     (trace_data),
        .trace_strobe   (trace_strobe),
        .aux_data       (aux_data),
        .aux_req        (aux_req),
        .aux_ack        (aux_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #5 mclk = ~mclk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;
    logic [31:0] xlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < xlog.size()) return xlog[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Reference model: a packet queue plus the output slot and aux bookkeeping
    logic [31:0] mq[$];
    bit          m_valid, m_ack, m_pend;
    logic [31:0] m_data;
    int          m_wait, m_ovf, m_run;

    task automatic model_reset();
        mq.delete();
        m_valid = 0; m_ack = 0; m_pend = 0;
        m_data = 32'h0; m_wait = 0; m_ovf = 0; m_run = 0;
    endtask

    task automatic count_drop();
        if (m_ovf < 65535) m_ovf++;
    endtask

    task automatic model_step();
        bit          slot_free, elig, urgent, take_aux, take_trace, room;
        logic [31:0] head;
        slot_free  = !m_valid || out_ready;
        elig       = aux_req && !m_ack;
        urgent     = elig && (m_wait >= AUX_MAX_WAIT);
        take_aux   = slot_free && (urgent || (elig && mq.size() == 0));
        take_trace = slot_free && !take_aux && mq.size() > 0;
        room       = (mq.size() < DEPTH) || take_trace;
        head       = 32'h0;
        if (take_trace) head = mq.pop_front();
`ifdef PACKET_ARB_OVF_MARKER_EN
        if (m_pend && room) begin
            mq.push_back({16'hFFFF, 16'(m_run)});
            if (trace_strobe) begin
                count_drop();
                m_run = 1;
            end else begin
                m_run  = 0;
                m_pend = 0;
            end
        end else if (trace_strobe) begin
            if (room) mq.push_back(trace_data);
            else begin
                count_drop();
                if (m_run < 65535) m_run++;
                m_pend = 1;
            end
        end
`else
        if (trace_strobe) begin
            if (room) mq.push_back(trace_data);
            else count_drop();
        end
`endif
        if (slot_free) begin
            if (take_aux) begin
                m_valid = 1; m_data = aux_data;
            end else if (take_trace) begin
                m_valid = 1; m_data = head;
            end else m_valid = 0;
        end
        m_ack = take_aux;
        if (take_aux) m_wait = 0;
        else if (elig && m_wait < AUX_MAX_WAIT) m_wait++;
    endtask

    always @(posedge mclk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge mclk) begin
        if (check_en && !reset) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) check("out_data", out_data, m_data);
            check("aux_ack", 32'(aux_ack), 32'(m_ack));
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("overflow_count", 32'(overflow_count), 32'(m_ovf));
            if (out_valid && out_ready) xlog.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_aux_ack", 32'(aux_ack), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        xlog.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sent, errs, aux_seen, tcount, bias;
        trace_strobe = 0; trace_data = 0; aux_req = 0; aux_data = 0; out_ready = 0;
        do_reset();
        check_en = 1;

        // three trace packets with a ready sink
        out_ready = 1;
        trace_data = 32'hA000_0000; trace_strobe = 1; tick();
        check("p1_level_e0", 32'(fifo_level), 32'd1);
        check("p1_valid_e0", 32'(out_valid), 32'd0);
        trace_data = 32'hA000_0001; tick();
        check("p1_valid_e1", 32'(out_valid), 32'd1);
        check("p1_data_e1", out_data, 32'hA000_0000);
        trace_data = 32'hA000_0002; tick();
        check("p1_data_e2", out_data, 32'hA000_0001);
        trace_strobe = 0;
        repeat (4) tick();
        check("p1_count", 32'(xlog.size()), 32'd3);
        check("p1_last", log_at(2), 32'hA000_0002);
        check("p1_level_end", 32'(fifo_level), 32'd0);

        // aux with empty FIFO; request held through the ack cycle
        do_reset();
        out_ready = 1; aux_data = 32'h1234_5678; aux_req = 1; tick();
        check("p2_ack", 32'(aux_ack), 32'd1);
        check("p2_aux_data", out_data, 32'h1234_5678);
        tick();
        check("p2_ack_once", 32'(aux_ack), 32'd0);
        check("p2_no_recapture", 32'(out_valid), 32'd0);
        aux_req = 0;
        repeat (3) tick();
        check("p2_aux_count", 32'(xlog.size()), 32'd1);

        // overflow with stalled sink, then drain
        do_reset();
        out_ready = 0; aux_data = 32'hC0DE_0001; aux_req = 1; tick();
        aux_req = 0;
        for (int i = 0; i < 20; i++) begin
            trace_data = 32'hB000_0000 + 32'(i); trace_strobe = 1; tick();
        end
        trace_strobe = 0; tick();
        check("p2_full_level", 32'(fifo_level), 32'd16);
        check("p2_overflow", 32'(overflow_count), 32'd4);
        out_ready = 1;
        repeat (25) tick();
`ifdef PACKET_ARB_OVF_MARKER_EN
        check("p2_drain_count", 32'(xlog.size()), 32'd18);
        check("p2_marker", log_at(17), 32'hFFFF_0004);
`else
        check("p2_drain_count", 32'(xlog.size()), 32'd17);
`endif
        check("p2_drain_first", log_at(0), 32'hC0DE_0001);
        check("p2_drain_b0", log_at(1), 32'hB000_0000);
        check("p2_drain_b15", log_at(16), 32'hB000_000F);

        // aux starvation bound under continuous trace traffic
        do_reset();
        out_ready = 1; sent = 0;
        for (int i = 0; i < 4; i++) begin
            trace_data = 32'hD000_0000 + 32'(sent); trace_strobe = 1; sent++; tick();
        end
        aux_data = 32'hAAAA_5555; aux_req = 1; n = 0;
        while (n < 200) begin
            trace_data = 32'hD000_0000 + 32'(sent); sent++; tick(); n++;
            if (aux_ack) break;
        end
        aux_req = 0; trace_strobe = 0;
        check("p3_wait_edges", 32'(n), 32'd65);
        repeat (10) tick();
        errs = 0; aux_seen = 0; tcount = 0;
        foreach (xlog[i]) begin
            if (xlog[i] == 32'hAAAA_5555) aux_seen++;
            else begin
                if (xlog[i] != 32'hD000_0000 + 32'(tcount)) errs++;
                tcount++;
            end
        end
        check("p3_trace_count", 32'(tcount), 32'(sent));
        check("p3_order_errs", 32'(errs), 32'd0);
        check("p3_aux_once", 32'(aux_seen), 32'd1);

        // randomized traffic with varying backpressure
        do_reset();
        bias = 4;
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 0) bias = int'($urandom_range(0, 4));
            out_ready    = (int'($urandom_range(0, 3)) < bias);
            trace_strobe = ($urandom_range(0, 2) != 0);
            trace_data   = $urandom();
            if (aux_req && aux_ack) aux_req = 0;
            else if (!aux_req && $urandom_range(0, 15) == 0) begin
                aux_req = 1; aux_data = $urandom();
            end
            tick();
        end
        aux_req = 0; trace_strobe = 0;

        // reset with buffered packets and a pending aux request
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 9; i++) begin
            trace_data = 32'hE000_0000 + 32'(i); trace_strobe = 1; tick();
        end
        trace_strobe = 0; aux_data = 32'h5A5A_5A5A; aux_req = 1;
        tick(); tick();
        check("p5_level", 32'(fifo_level), 32'd8);
        check("p5_no_ack", 32'(aux_ack), 32'd0);
        do_reset();
        aux_req = 0; out_ready = 1;
        repeat (5) tick();
        check("p5_post_ack", 32'(aux_ack), 32'd0);
        check("p5_post_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Merges the RAM trace packet stream and a low-priority auxiliary packet requester (config readback, status words) into the single 32-bit packet input of the USB FIFO interface. Trace packets are buffered in a small FIFO, so the USB side can apply backpressure without losing bursts. On FIFO overflow, packets are dropped and counted, and an optional marker packet is inserted. Sits between the tracing state machine / packet assembler and the USB communication block, all on mclk.

## Interface
- DEPTH_LOG2, 4, log2 of trace FIFO depth (16 entries)
- AUX_MAX_WAIT, 64, cycles an asserted aux request may wait before it preempts trace traffic
- mclk  in  1  master clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- trace_data  in  32  assembled trace packet
- trace_strobe  in  1  one-cycle packet valid; no backpressure to source
- aux_data  in  32  auxiliary packet, held stable while aux_req high
- aux_req  in  1  auxiliary request, level, held until aux_ack
- aux_ack  out  1  one-cycle pulse: aux_data captured
- out_data  out  32  packet to USB interface
- out_valid  out  1  out_data valid
- out_ready  in  1  USB side accepts; transfer when out_valid && out_ready
- fifo_level  out  DEPTH_LOG2+1  trace FIFO occupancy
- overflow_count  out  16  total dropped trace packets, saturating at 16'hFFFF

## Operation
- Reset values: aux_ack=0, out_valid=0, out_data=0, fifo_level=0, overflow_count=0, wait counter=0, ovf_pending=0, drop_run=0.
- FIFO write: trace_strobe && (!full || pop this edge). Otherwise the packet is dropped: overflow_count+1 (saturating), drop_run+1 (saturating 16'hFFFF), ovf_pending=1.
- Output register loads when !out_valid || out_ready ("slot free"). Grant order at each free slot:
  1. aux, if aux_req && wait counter >= AUX_MAX_WAIT && !aux_ack
  2. FIFO head, if FIFO non-empty (pop)
  3. aux, if aux_req && !aux_ack
  4. none: out_valid=0
- Grant FSM: states IDLE, TRACE, AUX record the source of the current out_data; IDLE when out_valid=0. Transitions follow the grant order above at each free slot.
- aux_ack is registered, high for the one cycle after the capture edge. Aux is ineligible while aux_ack=1, so a held request cannot be captured twice.
- Wait counter increments while aux_req && !aux_ack, saturates at AUX_MAX_WAIT, and clears on capture.
- A FIFO push and pop on the same edge leave fifo_level unchanged. A push when full is legal only with a simultaneous pop.
- out_data and out_valid hold while out_valid && !out_ready.
- Reset mid-operation discards FIFO contents, the output packet and any pending marker. No aux_ack is issued for an in-flight aux packet.

## Timing
- Trace latency: strobe at edge E is written to the FIFO at E. It loads to the output at E+1 if the slot is free; out_valid is high after E+1.
- Aux latency: req sampled at edge E with the FIFO empty and the slot free. Captured at E, out_valid after E, aux_ack high in cycle E..E+1.
- Sustained throughput: one packet per cycle while out_ready=1.

## Configuration
- PACKET_ARB_OVF_MARKER_EN defined: while ovf_pending, the first edge with FIFO not full writes marker {OVF_TAG, drop_run} into the FIFO, in place of any trace packet.
  - A trace_strobe on that edge is dropped and counted; drop_run restarts at 1, and ovf_pending stays 1.
  - Otherwise drop_run=0 and ovf_pending=0.
- Not defined: no marker. Drops only update overflow_count; drop_run and ovf_pending logic is absent.

## Structure
- Shared package: OVF_TAG = 16'hFFFF, marker field widths, grant state encodings (IDLE, TRACE, AUX).
- One sub-module: packet_fifo, a synchronous first-word-fall-through FIFO, 32-bit wide, 2**DEPTH_LOG2 deep, with push/pop/full/empty/level.

## Test plan
- 3 trace strobes, out_ready=1 -> out_valid from 2 cycles after the first strobe, 3 packets in order, fifo_level returns to 0.
- out_ready=0, 20 trace strobes (depth 16) -> fifo_level=16, overflow_count=4. With macro, after out_ready=1: 16 packets, then marker 32'hFFFF0004.
- aux_req with FIFO empty -> out_data=aux_data in the next cycle, single aux_ack pulse, no duplicate capture while req is held during the ack.
- Continuous trace strobes plus aux_req, AUX_MAX_WAIT=64 -> aux captured after exactly 64 waiting cycles, trace order preserved.
- out_ready toggling 1/0 with packets pending -> out_data stable while not ready, no loss, no duplication.
- reset pulsed with 8 packets buffered and aux pending -> all outputs at reset values, FIFO empty, no aux_ack.
